// File: rtl/pic_pkg.sv
// Shared definitions for the 8259A in-service / acknowledge logic:
// OCW2 command codes, the spurious level, the FSM state type and bit helpers.
package pic_pkg;

  localparam int NUM_IRQ = 8;

  localparam logic [2:0] OCW2_CLR_ROT_AEOI = 3'b000;
  localparam logic [2:0] OCW2_NSEOI        = 3'b001;
  localparam logic [2:0] OCW2_NOP          = 3'b010;
  localparam logic [2:0] OCW2_SEOI         = 3'b011;
  localparam logic [2:0] OCW2_SET_ROT_AEOI = 3'b100;
  localparam logic [2:0] OCW2_ROT_NSEOI    = 3'b101;
  localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
  localparam logic [2:0] OCW2_ROT_SEOI     = 3'b111;

  localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ACK1,
    ST_WAIT2,
    ST_ACK2
  } state_t;

  function automatic logic [7:0] onehot(input logic [2:0] lvl);
    return 8'b0000_0001 << lvl;
  endfunction

  function automatic logic [2:0] encode(input logic [7:0] vec);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (vec[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/isr_priority_find.sv
// Rotated highest-priority scan over the ISR: starts one above the marker bit
// (bit 0 when no marker is set) and wraps upward.
module isr_priority_find
  import pic_pkg::*;
(
  input  logic [7:0] isr,
  input  logic [7:0] marker,
  output logic       found,
  output logic [2:0] level
);

  logic [2:0] start;
  logic [2:0] idx;

  always_comb begin
    start = 3'd0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (marker[i]) start = 3'(i + 1);
    end
    found = 1'b0;
    level = 3'd0;
    idx   = 3'd0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      idx = start + 3'(i);
      if (!found && isr[idx]) begin
        found = 1'b1;
        level = idx;
      end
    end
  end

endmodule

// File: rtl/in_service_control.sv
// 8259A in-service control: INT/INTA handshake FSM, ISR and rotation marker
// ownership, 8086 vector output and OCW2 EOI/rotate execution.
module in_service_control
  import pic_pkg::*;
#(
  parameter int INTA_SYNC_FF = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] interrupt,
  input  logic       inta_n,
  input  logic       aeoi_mode,
  input  logic [4:0] vector_base,
  input  logic       ocw2_valid,
  input  logic [2:0] ocw2_cmd,
  input  logic [2:0] ocw2_level,
  output logic       int_o,
  output logic [7:0] clear_irr,
  output logic [7:0] in_service_register,
  output logic [7:0] highest_level_in_service,
  output logic [7:0] data_o,
  output logic       data_oe
);

  state_t                  state;
  logic [INTA_SYNC_FF-1:0] inta_sync;
  logic                    inta_d;
  logic                    fall_e;
  logic                    rise_e;
  logic [2:0]              lvl;
  logic                    spurious;
  logic                    seen_rise;
  logic                    rot_aeoi;
  logic                    ocw2_q_valid;
  logic [2:0]              ocw2_q_cmd;
  logic [2:0]              ocw2_q_level;
  logic                    ns_found;
  logic [2:0]              ns_level;
  logic [7:0]              isr_set;
  logic [7:0]              isr_clr;
  logic [7:0]              isr_next;
  logic [7:0]              marker_next;
  logic                    rot_next;

  assign fall_e = inta_d & ~inta_sync[INTA_SYNC_FF-1];
  assign rise_e = ~inta_d & inta_sync[INTA_SYNC_FF-1];

  isr_priority_find u_find (
    .isr    (in_service_register),
    .marker (highest_level_in_service),
    .found  (ns_found),
    .level  (ns_level)
  );

  // Set from ACK1 is applied after all clears so it wins a same-cycle EOI.
  always_comb begin
    isr_set     = 8'h00;
    isr_clr     = 8'h00;
    marker_next = highest_level_in_service;
    rot_next    = rot_aeoi;
    if (state == ST_ACK1 && !spurious) isr_set = onehot(lvl);
    if (state == ST_ACK2 && rise_e && aeoi_mode && !spurious) begin
      isr_clr = onehot(lvl);
      if (rot_aeoi) marker_next = onehot(lvl);
    end
    if (ocw2_q_valid) begin
      case (ocw2_q_cmd)
        OCW2_NSEOI: begin
          if (ns_found) isr_clr = isr_clr | onehot(ns_level);
        end
        OCW2_SEOI: isr_clr = isr_clr | onehot(ocw2_q_level);
        OCW2_ROT_NSEOI: begin
          if (ns_found) begin
            isr_clr     = isr_clr | onehot(ns_level);
            marker_next = onehot(ns_level);
          end
        end
        OCW2_ROT_SEOI: begin
          isr_clr     = isr_clr | onehot(ocw2_q_level);
          marker_next = onehot(ocw2_q_level);
        end
        OCW2_SET_PRIO:     marker_next = onehot(ocw2_q_level);
        OCW2_SET_ROT_AEOI: rot_next = 1'b1;
        OCW2_CLR_ROT_AEOI: rot_next = 1'b0;
        default: ;
      endcase
    end
    isr_next = (in_service_register & ~isr_clr) | isr_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                    <= ST_IDLE;
      inta_sync                <= '1;
      inta_d                   <= 1'b1;
      lvl                      <= 3'd0;
      spurious                 <= 1'b0;
      seen_rise                <= 1'b0;
      rot_aeoi                 <= 1'b0;
      ocw2_q_valid             <= 1'b0;
      ocw2_q_cmd               <= 3'd0;
      ocw2_q_level             <= 3'd0;
      int_o                    <= 1'b0;
      clear_irr                <= 8'h00;
      in_service_register      <= 8'h00;
      highest_level_in_service <= 8'h00;
      data_o                   <= 8'h00;
      data_oe                  <= 1'b0;
    end else begin
      inta_sync                <= {inta_sync[INTA_SYNC_FF-2:0], inta_n};
      inta_d                   <= inta_sync[INTA_SYNC_FF-1];
      ocw2_q_valid             <= ocw2_valid;
      ocw2_q_cmd               <= ocw2_cmd;
      ocw2_q_level             <= ocw2_level;
      in_service_register      <= isr_next;
      highest_level_in_service <= marker_next;
      rot_aeoi                 <= rot_next;
      clear_irr                <= 8'h00;
      case (state)
        ST_IDLE: begin
          if (interrupt != 8'h00 && in_service_register == 8'h00) begin
            state <= ST_REQ;
            int_o <= 1'b1;
          end
        end
        ST_REQ: begin
          if (fall_e) begin
            state     <= ST_ACK1;
            int_o     <= 1'b0;
            seen_rise <= 1'b0;
            if (interrupt != 8'h00) begin
              lvl       <= encode(interrupt);
              spurious  <= 1'b0;
              clear_irr <= onehot(encode(interrupt));
            end else begin
              lvl      <= SPURIOUS_LEVEL;
              spurious <= 1'b1;
            end
          end
        end
        ST_ACK1: begin
          state <= ST_WAIT2;
          if (rise_e) seen_rise <= 1'b1;
        end
        ST_WAIT2: begin
          if (rise_e) seen_rise <= 1'b1;
          if (fall_e && seen_rise) begin
            state   <= ST_ACK2;
            data_oe <= 1'b1;
            data_o  <= {vector_base, lvl};
          end
        end
        ST_ACK2: begin
          if (rise_e) begin
            state   <= ST_IDLE;
            data_oe <= 1'b0;
            data_o  <= 8'h00;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
